drv7seg_scan: RTL and testbench

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It accepts a packed hex value, per-digit decimal points and blank masks, and double-buffers them so a frame never shows mixed old/new data. It scans the digits with a programmable slot length and an anti-ghosting blank interval, and optionally suppresses leading zeros. It sits between CPU/peripheral registers and the board display pins, replacing per-digit static decoders.

---
 rtl/drv7seg_scan.sv | 175 +++++++++++++++++
 tb/tb_drv7seg_scan.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drv7seg_scan.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered data,
// anti-ghost blank window per slot and optional leading-zero suppression.
module drv7seg_scan #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic                    lz_sup,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     dig,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [31:0]         BLANK_U  = 32'(BLANK_CYCLES);
  localparam logic [7:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                   : {N_DIGITS{1'b0}};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h7E;
      4'h1: code = 7'h30;
      4'h2: code = 7'h6D;
      4'h3: code = 7'h79;
      4'h4: code = 7'h33;
      4'h5: code = 7'h5B;
      4'h6: code = 7'h5F;
      4'h7: code = 7'h70;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h7B;
      4'hA: code = 7'h77;
      4'hB: code = 7'h1F;
      4'hC: code = 7'h4E;
      4'hD: code = 7'h3D;
      4'hE: code = 7'h4F;
      default: code = 7'h47;
    endcase
    return code;
  endfunction

  // Scan position and buffers
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*N_DIGITS-1:0] shd_val_q, shd_val_d;
  logic [N_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [N_DIGITS-1:0]   shd_blank_q, shd_blank_d;

  // Registered outputs
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic                  fd_q, fd_d;

  logic                  transfer;
  logic                  in_blank;
  logic [N_DIGITS-1:0]   lz_mask;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_lz;
  logic [7:0]            seg_show;
  logic [N_DIGITS-1:0]   dig_onehot;

  // The first cycle of slot 0 latches pending into shadow; a load landing on
  // that same cycle bypasses straight through so it is not delayed a frame.
  always_comb begin
    transfer     = en && (cnt_q == '0) && (idx_q == '0);
    pend_val_d   = load ? value    : pend_val_q;
    pend_dp_d    = load ? dp_in    : pend_dp_q;
    pend_blank_d = load ? blank_in : pend_blank_q;
    shd_val_d    = transfer ? pend_val_d   : shd_val_q;
    shd_dp_d     = transfer ? pend_dp_d    : shd_dp_q;
    shd_blank_d  = transfer ? pend_blank_d : shd_blank_q;
  end

  // Walk from the most significant digit down; a visible nonzero digit ends
  // the run of suppressible zeros.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    lz_mask = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_mask[i] = lz_sup && !seen_nz && (shd_val_d[4*i +: 4] == 4'h0) && (i != 0);
      if ((shd_val_d[4*i +: 4] != 4'h0) && !shd_blank_d[i]) begin
        seen_nz = 1'b1;
      end
    end
  end

  always_comb begin
    cur_nib    = shd_val_d[4*int'(idx_q) +: 4];
    cur_dp     = shd_dp_d[idx_q];
    cur_blank  = shd_blank_d[idx_q];
    cur_lz     = lz_mask[idx_q];
    in_blank   = (32'(cnt_q) < BLANK_U);
    dig_onehot = N_DIGITS'(1) << idx_q;
    if (cur_blank) begin
      seg_show = 8'h00;
    end else begin
      seg_show = {(cur_lz ? 7'h00 : seg_decode(cur_nib)), cur_dp};
    end
  end

  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    fd_d  = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
      end
      if (!in_blank) begin
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_show : seg_show;
        dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_onehot : dig_onehot;
      end
      fd_d = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      shd_val_q    <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      fd_q         <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_drv7seg_scan.sv
// Directed bench for drv7seg_scan: a default-polarity instance and an
// inverted-polarity instance share stimulus and are checked cycle by cycle.
module tb_drv7seg_scan;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic          lz_sup;
  logic [7:0]    seg, iseg;
  logic [3:0]    dig, idig;
  logic          frame_done, ifd;

  int checks   = 0;
  int failures = 0;
  int step     = 0;

  always #5 clk = ~clk;

  drv7seg_scan #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_in(blank_in), .lz_sup(lz_sup),
    .seg(seg), .dig(dig), .frame_done(frame_done)
  );

  drv7seg_scan #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
  ) u_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_in(blank_in), .lz_sup(lz_sup),
    .seg(iseg), .dig(idig), .frame_done(ifd)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_off();
    chk("seg_off", seg, 8'h00);
    chk("dig_off", dig, 4'hF);
    chk("fd_off", frame_done, 1'b0);
    chk("iseg_off", iseg, 8'hFF);
    chk("idig_off", idig, 4'h0);
    chk("ifd_off", ifd, 1'b0);
  endtask

  task automatic check_cycle(input int c, input logic [3:0] ed, input logic [7:0] es,
                             input bit fd_last);
    logic       exp_fd;
    logic [7:0] ies;
    logic [3:0] ied;
    exp_fd = fd_last && (c == SD - 1);
    ies    = ~es;
    ied    = ~ed;
    if (c < BC) begin
      chk("seg_blankwin", seg, 8'h00);
      chk("dig_blankwin", dig, 4'hF);
      chk("iseg_blankwin", iseg, 8'hFF);
      chk("idig_blankwin", idig, 4'h0);
    end else begin
      chk("seg", seg, es);
      chk("dig", dig, ed);
      chk("iseg", iseg, ies);
      chk("idig", idig, ied);
    end
    chk("frame_done", frame_done, exp_fd);
    chk("ifd", ifd, exp_fd);
  endtask

  // Entered at output cycle 0 of a slot; leaves at cycle 0 of the next slot.
  task automatic slot_ld(input logic [3:0] ed, input logic [7:0] es, input bit fd_last,
                         input int ld_cyc, input logic [15:0] lv, input logic [3:0] lp,
                         input logic [3:0] lb);
    for (int c = 0; c < SD; c++) begin
      check_cycle(c, ed, es, fd_last);
      if (c == ld_cyc) begin
        value    = lv;
        dp_in    = lp;
        blank_in = lb;
        load     = 1'b1;
      end
      tick();
      load = 1'b0;
    end
  endtask

  task automatic slot(input logic [3:0] ed, input logic [7:0] es, input bit fd_last);
    slot_ld(ed, es, fd_last, -1, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    slot(4'b1110, s0, 1'b0);
    slot(4'b1101, s1, 1'b0);
    slot(4'b1011, s2, 1'b0);
    slot(4'b0111, s3, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_in = 4'h0;
    lz_sup   = 1'b0;

    // Reset state, then load while disabled
    step = 1;
    #12;
    check_off();
    rst_n = 1'b1;
    tick();
    check_off();
    value = 16'h12AF;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check_off();
    en = 1'b1;
    tick();

    // Basic scan of 12AF
    step = 2;
    frame(8'h8E, 8'hEE, 8'hDA, 8'h60);

    // Loads mid-frame stay pending until the next frame
    step = 3;
    slot(4'b1110, 8'h8E, 1'b0);
    slot(4'b1101, 8'hEE, 1'b0);
    slot_ld(4'b1011, 8'hDA, 1'b0, 3, 16'h1111, 4'h0, 4'h0);
    slot_ld(4'b0111, 8'h60, 1'b1, 3, 16'h2222, 4'h0, 4'h0);

    // Next frame shows 2222; load lands exactly on the transfer edge
    step = 4;
    slot(4'b1110, 8'hDA, 1'b0);
    slot(4'b1101, 8'hDA, 1'b0);
    slot(4'b1011, 8'hDA, 1'b0);
    slot_ld(4'b0111, 8'hDA, 1'b1, 7, 16'h3333, 4'h0, 4'h0);

    // Bypassed 3333 visible; queue 0050 with dp on digit 3
    step = 5;
    lz_sup = 1'b1;
    slot_ld(4'b1110, 8'hF2, 1'b0, 3, 16'h0050, 4'b1000, 4'h0);
    slot(4'b1101, 8'hF2, 1'b0);
    slot(4'b1011, 8'hF2, 1'b0);
    slot(4'b0111, 8'hF2, 1'b1);

    // Leading-zero suppression of 0050
    step = 6;
    slot_ld(4'b1110, 8'hFC, 1'b0, 3, 16'h0000, 4'h0, 4'h0);
    slot(4'b1101, 8'hB6, 1'b0);
    slot(4'b1011, 8'h00, 1'b0);
    slot(4'b0111, 8'h01, 1'b1);

    // All zeros: only digit 0 shows
    step = 7;
    slot_ld(4'b1110, 8'hFC, 1'b0, 3, 16'h8888, 4'hF, 4'b0010);
    slot(4'b1101, 8'h00, 1'b0);
    slot(4'b1011, 8'h00, 1'b0);
    slot(4'b0111, 8'h00, 1'b1);

    // Blank mask on digit 1
    step = 8;
    lz_sup = 1'b0;
    slot_ld(4'b1110, 8'hFF, 1'b0, 3, 16'h8888, 4'h0, 4'h0);
    slot(4'b1101, 8'h00, 1'b0);
    slot(4'b1011, 8'hFF, 1'b0);
    slot(4'b0111, 8'hFF, 1'b1);

    // Plain 8s without dp (inverted instance shows 01)
    step = 9;
    frame(8'hFE, 8'hFE, 8'hFE, 8'hFE);

    // Drop en mid slot 2, load while disabled, re-enable
    step = 10;
    slot(4'b1110, 8'hFE, 1'b0);
    slot(4'b1101, 8'hFE, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check_cycle(c, 4'b1011, 8'hFE, 1'b0);
      tick();
    end
    check_cycle(4, 4'b1011, 8'hFE, 1'b0);
    en       = 1'b0;
    value    = 16'h4444;
    dp_in    = 4'h0;
    blank_in = 4'h0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    check_off();
    for (int k = 1; k < 5; k++) begin
      tick();
      check_off();
    end
    en = 1'b1;
    tick();

    // Restart at slot 0 with the pending 4444
    step = 11;
    frame(8'h66, 8'h66, 8'h66, 8'h66);

    // Asynchronous reset mid-frame
    step = 12;
    slot(4'b1110, 8'h66, 1'b0);
    slot(4'b1101, 8'h66, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check_cycle(c, 4'b1011, 8'h66, 1'b0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_off();
    #1;
    rst_n = 1'b1;
    tick();

    // Cleared buffers display zeros
    step = 13;
    frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
